// File: rtl/fetch_cur_chroma_loader.sv
// Chroma current-LCU loader: fetches the U and V planes (32 rows each) into the ping-pong buffer.
// FETCH_CUR_CHROMA_PAD_EN enables bottom-edge row replication for partial LCUs.
module fetch_cur_chroma_loader #(
    parameter int BURST_MAX   = 32,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sysif_start_i,
    input  logic [6:0]                sysif_lcu_x_i,
    input  logic [6:0]                sysif_lcu_y_i,
    input  logic [12:0]               sysif_pic_height_i,
    output logic                      ext_req_o,
    input  logic                      ext_req_ack_i,
    output logic                      ext_req_plane_o,
    output logic [6:0]                ext_req_x_o,
    output logic [6:0]                ext_req_y_o,
    output logic [5:0]                ext_req_len_o,
    input  logic                      ext_data_valid_i,
    input  logic [32*PIXEL_WIDTH-1:0] ext_data_i,
    output logic                      ext_load_valid_o,
    output logic [5:0]                ext_load_addr_o,
    output logic [32*PIXEL_WIDTH-1:0] ext_load_data_o,
    output logic                      ext_load_done_o,
    output logic                      busy_o,
    output logic                      err_o
);

    typedef enum logic [2:0] {
        IDLE, REQ_U, DAT_U, PAD_U, REQ_V, DAT_V, PAD_V, DONE
    } state_t;

    state_t     state;
    logic [5:0] rows_valid;
    logic [4:0] row;
    logic [5:0] start_rows;

`ifdef FETCH_CUR_CHROMA_PAD_EN
    // Rows left below this LCU's top edge in chroma units; 0 or >=32 means the LCU is full.
    function automatic logic [5:0] calc_rows_valid(input logic [11:0] half_height,
                                                   input logic [6:0]  lcu_y);
        logic [11:0] rem;
        rem = half_height - {lcu_y, 5'b0};
        if (rem == 12'd0 || rem >= 12'(BURST_MAX))
            return 6'(BURST_MAX);
        return rem[5:0];
    endfunction

    logic unused_height_lsb;
    assign unused_height_lsb = sysif_pic_height_i[0];
    assign start_rows = calc_rows_valid(sysif_pic_height_i[12:1], sysif_lcu_y_i);
`else
    logic unused_height;
    assign unused_height = ^sysif_pic_height_i;
    assign start_rows = 6'(BURST_MAX);
`endif

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            rows_valid       <= '0;
            row              <= '0;
            ext_req_o        <= 1'b0;
            ext_req_plane_o  <= 1'b0;
            ext_req_x_o      <= '0;
            ext_req_y_o      <= '0;
            ext_req_len_o    <= '0;
            ext_load_valid_o <= 1'b0;
            ext_load_addr_o  <= '0;
            ext_load_data_o  <= '0;
            ext_load_done_o  <= 1'b0;
            err_o            <= 1'b0;
        end else begin
            ext_load_valid_o <= 1'b0;
            ext_load_done_o  <= 1'b0;
            if (sysif_start_i && state != IDLE)
                err_o <= 1'b1;

            case (state)
                IDLE: begin
                    if (sysif_start_i) begin
                        ext_req_x_o     <= sysif_lcu_x_i;
                        ext_req_y_o     <= sysif_lcu_y_i;
                        rows_valid      <= start_rows;
                        ext_req_len_o   <= start_rows;
                        ext_req_plane_o <= 1'b0;
                        ext_req_o       <= 1'b1;
                        state           <= REQ_U;
                    end
                end

                REQ_U, REQ_V: begin
                    if (ext_req_ack_i) begin
                        ext_req_o <= 1'b0;
                        row       <= '0;
                        state     <= (state == REQ_U) ? DAT_U : DAT_V;
                    end
                end

                DAT_U, DAT_V: begin
                    if (ext_data_valid_i) begin
                        ext_load_valid_o <= 1'b1;
                        ext_load_addr_o  <= {ext_req_plane_o, row};
                        ext_load_data_o  <= ext_data_i;
                        if (row != 5'd31)
                            row <= row + 5'd1;
                        if ({1'b0, row} == rows_valid - 6'd1) begin
                            if (rows_valid < 6'(BURST_MAX))
                                state <= (state == DAT_U) ? PAD_U : PAD_V;
                            else if (state == DAT_U) begin
                                ext_req_plane_o <= 1'b1;
                                ext_req_o       <= 1'b1;
                                state           <= REQ_V;
                            end else
                                state <= DONE;
                        end
                    end
                end

                // ext_load_data_o still holds the last received row, so padding only advances the address.
                PAD_U, PAD_V: begin
                    ext_load_valid_o <= 1'b1;
                    ext_load_addr_o  <= {ext_req_plane_o, row};
                    if (row == 5'd31) begin
                        if (state == PAD_U) begin
                            ext_req_plane_o <= 1'b1;
                            ext_req_o       <= 1'b1;
                            state           <= REQ_V;
                        end else
                            state <= DONE;
                    end else
                        row <= row + 5'd1;
                end

                // First cycle raises the pulse, second cycle returns to IDLE so busy_o falls after it.
                DONE: begin
                    if (!ext_load_done_o)
                        ext_load_done_o <= 1'b1;
                    else
                        state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_cur_chroma_loader.sv
// Self-checking bench for fetch_cur_chroma_loader: table-driven loads, random loads and corner sequences.
module tb_fetch_cur_chroma_loader;
    localparam int PW = 8;
    localparam int RW = 32 * PW;

    logic          clk = 1'b0;
    logic          rst;
    logic          sysif_start_i;
    logic [6:0]    sysif_lcu_x_i, sysif_lcu_y_i;
    logic [12:0]   sysif_pic_height_i;
    logic          ext_req_o, ext_req_ack_i, ext_req_plane_o;
    logic [6:0]    ext_req_x_o, ext_req_y_o;
    logic [5:0]    ext_req_len_o;
    logic          ext_data_valid_i;
    logic [RW-1:0] ext_data_i;
    logic          ext_load_valid_o;
    logic [5:0]    ext_load_addr_o;
    logic [RW-1:0] ext_load_data_o;
    logic          ext_load_done_o, busy_o, err_o;

    fetch_cur_chroma_loader #(.BURST_MAX(32), .PIXEL_WIDTH(PW)) dut (
        .clk(clk), .rst(rst),
        .sysif_start_i(sysif_start_i), .sysif_lcu_x_i(sysif_lcu_x_i),
        .sysif_lcu_y_i(sysif_lcu_y_i), .sysif_pic_height_i(sysif_pic_height_i),
        .ext_req_o(ext_req_o), .ext_req_ack_i(ext_req_ack_i),
        .ext_req_plane_o(ext_req_plane_o), .ext_req_x_o(ext_req_x_o),
        .ext_req_y_o(ext_req_y_o), .ext_req_len_o(ext_req_len_o),
        .ext_data_valid_i(ext_data_valid_i), .ext_data_i(ext_data_i),
        .ext_load_valid_o(ext_load_valid_o), .ext_load_addr_o(ext_load_addr_o),
        .ext_load_data_o(ext_load_data_o), .ext_load_done_o(ext_load_done_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed buffer writes and done pulses
    typedef struct {
        int            a;
        logic [RW-1:0] d;
        int            c;
    } wr_t;
    wr_t wr_q[$];
    int  done_cyc[$];

    always @(negedge clk) begin
        wr_t w;
        if (ext_load_valid_o) begin
            w.a = int'(ext_load_addr_o);
            w.d = ext_load_data_o;
            w.c = cyc;
            wr_q.push_back(w);
        end
        if (ext_load_done_o)
            done_cyc.push_back(cyc);
    end

    // External memory responder state
    int            resp_delay;
    bit            resp_toggle;
    int            pend;
    bit            phase;
    int            wait_cnt;
    int            cur_plane;
    logic [RW-1:0] beats_u[$], beats_v[$];
    int            bcyc_u[$], bcyc_v[$];
    bit            req_seen[2];
    int            req_len[2], req_cyc[2], req_x[2], req_y[2];
    bit            exp_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int i = 0; i < RW / 32; i++)
            r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Rows fetched per plane, from the picture-height rule
    function automatic int model_rows(input int h, input int y);
        int rem;
        rem = ((h / 2) - y * 32) % 4096;
        if (rem < 0) rem += 4096;
`ifdef FETCH_CUR_CHROMA_PAD_EN
        return (rem == 0 || rem >= 32) ? 32 : rem;
`else
        return 32;
`endif
    endfunction

    task automatic step();
        int p;
        @(posedge clk);
        #1;
        ext_req_ack_i    = 1'b0;
        ext_data_valid_i = 1'b0;
        if (ext_req_o) begin
            p = int'(ext_req_plane_o);
            if (!req_seen[p]) begin
                req_seen[p] = 1'b1;
                req_len[p]  = int'(ext_req_len_o);
                req_cyc[p]  = cyc;
                req_x[p]    = int'(ext_req_x_o);
                req_y[p]    = int'(ext_req_y_o);
            end
        end
        if (pend > 0) begin
            if (!resp_toggle || phase) begin
                ext_data_valid_i = 1'b1;
                ext_data_i       = rand_row();
                if (cur_plane == 0) begin beats_u.push_back(ext_data_i); bcyc_u.push_back(cyc); end
                else                begin beats_v.push_back(ext_data_i); bcyc_v.push_back(cyc); end
                pend--;
            end
            phase = ~phase;
        end else if (ext_req_o) begin
            if (wait_cnt >= resp_delay) begin
                ext_req_ack_i = 1'b1;
                pend          = int'(ext_req_len_o);
                cur_plane     = int'(ext_req_plane_o);
                wait_cnt      = 0;
                phase         = 1'b1;
            end else
                wait_cnt++;
        end
    endtask

    task automatic clear_model();
        wr_q.delete(); done_cyc.delete();
        beats_u.delete(); beats_v.delete(); bcyc_u.delete(); bcyc_v.delete();
        req_seen[0] = 0; req_seen[1] = 0;
        req_len[0] = -1; req_len[1] = -1;
        pend = 0; wait_cnt = 0; phase = 0;
    endtask

    // poke: 0 none, 1 start pulse during U data phase, 2 start pulse during the done cycle
    task automatic run_load(input int x, input int y, input int h, input int delay,
                            input bit toggle, input int exp_len, input int poke);
        int            t0, n, lim, last_wc, bc;
        bit            poked;
        logic [RW-1:0] e;
        clear_model();
        resp_delay  = delay;
        resp_toggle = toggle;
        poked       = 0;
        step();
        sysif_start_i      = 1'b1;
        sysif_lcu_x_i      = 7'(x);
        sysif_lcu_y_i      = 7'(y);
        sysif_pic_height_i = 13'(h);
        t0 = cyc;
        step();
        sysif_start_i = 1'b0;
        n = 0;
        while (done_cyc.size() == 0 && n < 800) begin
            step();
            n++;
            sysif_start_i = 1'b0;
            if (poke == 1 && !poked && beats_u.size() == 5) begin
                sysif_start_i = 1'b1; poked = 1; exp_err = 1;
            end
            if (poke == 2 && ext_load_done_o) begin
                sysif_start_i = 1'b1; exp_err = 1;
            end
        end
        sysif_start_i = 1'b0;
        chk("busy_after_done", busy_o, 0);
        chk("no_req_after_done", ext_req_o, 0);
        for (int i = 0; i < 3; i++) step();

        chk("req_u_cycle", req_cyc[0], t0 + 1);
        chk("req_u_len", req_len[0], exp_len);
        chk("req_v_len", req_len[1], exp_len);
        chk("req_x", req_x[0], x);
        chk("req_y", req_y[0], y);
        chk("beats_u", beats_u.size(), exp_len);
        chk("beats_v", beats_v.size(), exp_len);
        chk("write_count", wr_q.size(), 64);
        chk("done_count", done_cyc.size(), 1);
        chk("err", err_o, exp_err);
        if (wr_q.size() == 64 && beats_u.size() == exp_len && beats_v.size() == exp_len) begin
            for (int i = 0; i < 64; i++) begin
                lim = i % 32;
                if (i < 32) e = (lim < exp_len) ? beats_u[lim] : beats_u[exp_len-1];
                else        e = (lim < exp_len) ? beats_v[lim] : beats_v[exp_len-1];
                chk($sformatf("wr_addr[%0d]", i), wr_q[i].a, i);
                n_tests++;
                if (wr_q[i].d !== e) begin
                    n_fail++;
                    $display("FAIL wr_data[%0d]: got %h expected %h", i, wr_q[i].d, e);
                end
                if (lim < exp_len) begin
                    bc = (i < 32) ? bcyc_u[lim] : bcyc_v[lim];
                    chk($sformatf("wr_cycle[%0d]", i), wr_q[i].c, bc + 1);
                end else
                    chk($sformatf("pad_cycle[%0d]", i), wr_q[i].c, wr_q[i-1].c + 1);
            end
            last_wc = wr_q[63].c;
            if (done_cyc.size() > 0)
                chk("done_after_last_write", done_cyc[0], last_wc + 1);
        end
    endtask

    typedef struct {
        int x, y, h, delay;
        bit toggle;
        int len_pad;
    } vec_t;
    vec_t tbl[8];

    initial begin
        int el, rx, ry, rh, n;
        tbl[0] = '{x: 0,  y: 0,  h: 1080, delay: 0, toggle: 0, len_pad: 32};
        tbl[1] = '{x: 5,  y: 1,  h: 72,   delay: 0, toggle: 0, len_pad: 4};
        tbl[2] = '{x: 3,  y: 2,  h: 1080, delay: 5, toggle: 1, len_pad: 32};
        tbl[3] = '{x: 1,  y: 33, h: 1080, delay: 1, toggle: 0, len_pad: 32};
        tbl[4] = '{x: 2,  y: 16, h: 1080, delay: 2, toggle: 1, len_pad: 28};
        tbl[5] = '{x: 7,  y: 0,  h: 40,   delay: 0, toggle: 0, len_pad: 20};
        tbl[6] = '{x: 0,  y: 2,  h: 130,  delay: 3, toggle: 1, len_pad: 1};
        tbl[7] = '{x: 127,y: 1,  h: 64,   delay: 0, toggle: 0, len_pad: 32};

        rst = 1'b1;
        sysif_start_i = 0; sysif_lcu_x_i = 0; sysif_lcu_y_i = 0; sysif_pic_height_i = 0;
        ext_req_ack_i = 0; ext_data_valid_i = 0; ext_data_i = '0;
        exp_err = 0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", ext_req_o, 0);
        chk("rst_valid", ext_load_valid_o, 0);
        chk("rst_addr", ext_load_addr_o, 0);
        chk("rst_done", ext_load_done_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
`ifdef FETCH_CUR_CHROMA_PAD_EN
            el = tbl[i].len_pad;
`else
            el = 32;
`endif
            run_load(tbl[i].x, tbl[i].y, tbl[i].h, tbl[i].delay, tbl[i].toggle, el, 0);
        end

        for (int i = 0; i < 6; i++) begin
            rx = $urandom_range(0, 127);
            ry = $urandom_range(0, 40);
            rh = $urandom_range(2, 8191);
            run_load(rx, ry, rh, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                     model_rows(rh, ry), 0);
        end

        // Start while busy, then start on the done pulse: both ignored, err sticky
        run_load(4, 0, 1080, 0, 0, 32, 1);
        run_load(9, 1, 72, 0, 0, model_rows(72, 1), 2);

        // Reset in the middle of the U burst
        clear_model();
        resp_delay = 0; resp_toggle = 0;
        step();
        sysif_start_i = 1'b1; sysif_lcu_x_i = 7'd6; sysif_lcu_y_i = 7'd0; sysif_pic_height_i = 13'd1080;
        step();
        sysif_start_i = 1'b0;
        n = 0;
        while (beats_u.size() < 10 && n < 200) begin step(); n++; end
        chk("beats_before_reset", beats_u.size(), 10);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", ext_load_valid_o, 0);
        chk("mid_rst_req", ext_req_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_err", err_o, 0);
        chk("mid_rst_addr", ext_load_addr_o, 0);
        wr_q.delete(); done_cyc.delete();
        step();
        rst = 1'b0;
        exp_err = 0;
        for (int i = 0; i < 30; i++) step();
        chk("writes_after_reset", wr_q.size(), 0);
        chk("done_after_reset", done_cyc.size(), 0);
        chk("idle_after_reset", busy_o, 0);
        run_load(6, 0, 1080, 0, 0, 32, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
